// File: rtl/sram_1p_ctrl.sv
// Single-port SRAM controller: clears the array after reset, then arbitrates
// one write/read request pair per cycle with write priority and a read starvation guard.
module sram_1p_ctrl #(
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 13,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              init_done,
    output logic              sram_en,
    output logic              sram_wmode,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W:0]     INIT_LAST  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W:0]     init_cnt;
    logic [ADDR_W:0]     init_cnt_next;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;
    logic                force_read;
    logic                write_win;
    logic                read_win;
    logic                read_hs;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            init_cnt   <= '0;
            starve_cnt <= '0;
            init_done  <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_next;
            init_cnt   <= init_cnt_next;
            starve_cnt <= starve_next;
            init_done  <= (state_next == RUN);
            resp_valid <= read_hs;
        end
    end

    // A read that has lost STARVE_LIMIT times in a row overrides write priority.
    assign force_read = r_valid && (starve_cnt == STARVE_MAX);
    assign write_win  = w_valid && !force_read;
    assign read_win   = r_valid && !write_win;

    always_comb begin
        state_next    = state;
        init_cnt_next = init_cnt;
        starve_next   = starve_cnt;
        w_ready       = 1'b0;
        r_ready       = 1'b0;
        read_hs       = 1'b0;
        sram_en       = 1'b0;
        sram_wmode    = 1'b0;
        sram_addr     = '0;
        sram_wdata    = '0;

        case (state)
            INIT: begin
                sram_en       = 1'b1;
                sram_wmode    = 1'b1;
                sram_addr     = init_cnt[ADDR_W-1:0];
                init_cnt_next = init_cnt + 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                w_ready    = !force_read;
                r_ready    = !w_valid || force_read;
                read_hs    = read_win;
                sram_en    = write_win || read_win;
                sram_wmode = write_win;
                sram_addr  = write_win ? w_addr : r_addr;
                sram_wdata = write_win ? w_data : '0;
                if (read_win || !r_valid) begin
                    starve_next = '0;
                end else if (write_win && starve_cnt != STARVE_MAX) begin
                    starve_next = starve_cnt + 1'b1;
                end
            end
            default: begin
                state_next = INIT;
            end
        endcase

        // Nothing reaches the SRAM or the requesters while reset is held.
        if (reset) begin
            sram_en = 1'b0;
            w_ready = 1'b0;
            r_ready = 1'b0;
            read_hs = 1'b0;
        end
    end

    assign resp_data = sram_rdata;

endmodule

// File: tb/tb_sram_1p_ctrl.sv
// Self-checking bench for sram_1p_ctrl: behavioural SRAM, reference memory/arbiter
// model, directed scenarios and a randomized traffic phase.
module tb_sram_1p_ctrl;

    localparam int DEPTH        = 256;
    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 13;
    localparam int STARVE_LIMIT = 4;

    logic              clock;
    logic              reset;
    logic              w_valid;
    logic              w_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              r_valid;
    logic              r_ready;
    logic [ADDR_W-1:0] r_addr;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              init_done;
    logic              sram_en;
    logic              sram_wmode;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    int testCount;
    int failCount;

    logic [DATA_W-1:0] sramArray [DEPTH];
    logic [DATA_W-1:0] refMem [DEPTH];
    int                refStarve;
    logic              refRespValid;
    logic [DATA_W-1:0] refRespData;
    logic              lastReadHs;

    sram_1p_ctrl #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_addr(w_addr),
        .w_data(w_data),
        .r_valid(r_valid),
        .r_ready(r_ready),
        .r_addr(r_addr),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .init_done(init_done),
        .sram_en(sram_en),
        .sram_wmode(sram_wmode),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural single-port SRAM with one-cycle read latency.
    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) sramArray[sram_addr] <= sram_wdata;
            else            sram_rdata <= sramArray[sram_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        refStarve    = 0;
        refRespValid = 1'b0;
        refRespData  = '0;
    endtask

    // Hold reset for a number of cycles with random request noise.
    task automatic doReset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            w_valid = 1'($urandom);
            r_valid = 1'($urandom);
            #1;
            checkOutput("rst_sram_en", sram_en, 0);
            @(posedge clock); #1;
        end
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_init_done", init_done, 0);
        reset = 1'b0;
    endtask

    // Walk the clearing sweep cycle by cycle, then confirm init_done.
    task automatic checkSweep();
        for (int i = 0; i < DEPTH; i++) begin
            w_valid = 1'($urandom);
            r_valid = 1'($urandom);
            w_addr  = ADDR_W'($urandom);
            r_addr  = ADDR_W'($urandom);
            w_data  = DATA_W'($urandom);
            #1;
            checkOutput("init_en", sram_en, 1);
            checkOutput("init_wmode", sram_wmode, 1);
            checkOutput("init_addr", sram_addr, i);
            checkOutput("init_wdata", sram_wdata, 0);
            checkOutput("init_w_ready", w_ready, 0);
            checkOutput("init_r_ready", r_ready, 0);
            checkOutput("init_done_low", init_done, 0);
            checkOutput("init_resp_valid", resp_valid, 0);
            @(posedge clock); #1;
        end
        w_valid = 1'b0;
        r_valid = 1'b0;
        #1;
        checkOutput("init_done_high", init_done, 1);
        clearModel();
    endtask

    // One RUN cycle: drive requests, compare against the reference, advance the model.
    task automatic applyStimulus(input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                                 input logic rv, input logic [ADDR_W-1:0] ra);
        logic forced;
        logic wWin;
        logic rWin;
        w_valid = wv;
        w_addr  = wa;
        w_data  = wd;
        r_valid = rv;
        r_addr  = ra;
        #1;
        forced = rv && (refStarve == STARVE_LIMIT);
        wWin   = wv && !forced;
        rWin   = rv && !wWin;
        lastReadHs = r_valid && r_ready;
        checkOutput("w_handshake", w_valid && w_ready, wWin);
        checkOutput("r_handshake", lastReadHs, rWin);
        checkOutput("sram_en", sram_en, wWin || rWin);
        if (wWin || rWin) begin
            checkOutput("sram_wmode", sram_wmode, wWin);
            checkOutput("sram_addr", sram_addr, wWin ? wa : ra);
        end
        if (wWin) checkOutput("sram_wdata", sram_wdata, wd);
        checkOutput("resp_valid", resp_valid, refRespValid);
        if (refRespValid) checkOutput("resp_data", resp_data, refRespData);

        refRespValid = rWin;
        if (rWin) refRespData = refMem[ra];
        if (wWin) refMem[wa] = wd;
        if (rWin || !rv)      refStarve = 0;
        else if (wWin && rv)  refStarve = (refStarve < STARVE_LIMIT) ? refStarve + 1 : STARVE_LIMIT;
        @(posedge clock); #1;
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        lastReadHs = 1'b0;
        reset   = 1'b1;
        w_valid = 1'b0;
        r_valid = 1'b0;
        w_addr  = '0;
        r_addr  = '0;
        w_data  = '0;
        sram_rdata = '0;
        for (int i = 0; i < DEPTH; i++) sramArray[i] = DATA_W'($urandom) | DATA_W'(1);
        clearModel();

        doReset(3);
        checkSweep();

        // Write then read back on the following cycle.
        applyStimulus(1'b1, 8'h05, 13'h1ABC, 1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b1, 8'h05);
        checkOutput("wr_rd_resp_valid", resp_valid, 1);
        checkOutput("wr_rd_resp_data", resp_data, 13'h1ABC);

        // Unwritten location reads back as cleared.
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b1, 8'h80);
        checkOutput("cleared_resp_valid", resp_valid, 1);
        checkOutput("cleared_resp_data", resp_data, 0);

        // Same-address collision with no starvation history: write first.
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b0, 8'h00);
        applyStimulus(1'b1, 8'h10, 13'h0777, 1'b1, 8'h10);
        checkOutput("collide_resp_valid", resp_valid, 0);
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b1, 8'h10);
        checkOutput("collide_resp_data", resp_data, 13'h0777);

        // Both requests held: four writes then one forced read, repeating.
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, ADDR_W'(8'h20 + i), DATA_W'($urandom), 1'b1, ADDR_W'(8'h20 + i));
            checkOutput("grant_pattern", lastReadHs, (i % 5) == 4);
        end
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b0, 8'h00);

        // Reset right after a read handshake drops the response and restarts the sweep.
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b1, 8'h05);
        doReset(2);
        checkSweep();
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b1, 8'h05);
        checkOutput("post_reset_cleared", resp_data, 0);

        // Randomized traffic over a narrow address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
                          ($urandom_range(0, 2) != 0), ADDR_W'($urandom_range(0, 15)));
        end
        applyStimulus(1'b0, 8'h00, 13'h0000, 1'b0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_1p_ctrl.md
SRAM_1P_CTRL -- requirements
Module: sram_1p_ctrl

Interface
REQ-001 Parameter: DEPTH, default 256, number of SRAM entries.
REQ-002 Parameter: ADDR_W, default 8, address width, equal to log2(DEPTH).
REQ-003 Parameter: DATA_W, default 13, data width.
REQ-004 Parameter: STARVE_LIMIT, default 4, number of consecutive write wins after which a pending read is forced through.
REQ-005 Port: clock  input  1  single clock for all logic; the SRAM shares this clock.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: w_valid  input  1  write request.
REQ-008 Port: w_ready  output  1  write accepted this cycle when w_valid is also high.
REQ-009 Port: w_addr  input  ADDR_W  write address.
REQ-010 Port: w_data  input  DATA_W  write data.
REQ-011 Port: r_valid  input  1  read request.
REQ-012 Port: r_ready  output  1  read accepted this cycle when r_valid is also high.
REQ-013 Port: r_addr  input  ADDR_W  read address.
REQ-014 Port: resp_valid  output  1  read data valid.
REQ-015 Port: resp_data  output  DATA_W  read data.
REQ-016 Port: init_done  output  1  high once the post-reset clear sweep has completed.
REQ-017 Port: sram_en  output  1  SRAM port enable.
REQ-018 Port: sram_wmode  output  1  SRAM write mode: 1 = write, 0 = read.
REQ-019 Port: sram_addr  output  ADDR_W  SRAM address.
REQ-020 Port: sram_wdata  output  DATA_W  SRAM write data.
REQ-021 Port: sram_rdata  input  DATA_W  SRAM read data, valid the cycle after a read enable.

Function
REQ-022 The controller SHALL implement two states: INIT and RUN.
REQ-023 In INIT it SHALL issue one write per cycle with sram_wdata=0, stepping an init counter from 0 to DEPTH-1; it SHALL then move to RUN and set init_done=1 on the following cycle.
REQ-024 In INIT, w_ready and r_ready SHALL be 0.
REQ-025 In RUN, at most one SRAM operation SHALL be issued per cycle, driven combinationally from the granted request.
REQ-026 Default priority in RUN: write over read.
REQ-027 Starvation counter: increment when r_valid && w_valid && write granted; saturate at STARVE_LIMIT; clear when a read is granted or when r_valid=0.
REQ-028 When the starvation counter equals STARVE_LIMIT and r_valid=1, the read SHALL win that cycle and w_ready SHALL be 0.
REQ-029 Handshake: w_ready=1 iff RUN and the write wins or there is no read; r_ready=1 iff RUN and (w_valid=0 or the read is forced by REQ-028).
REQ-030 Read latency: resp_valid SHALL be 1 exactly one cycle after a read handshake, with resp_data=sram_rdata; otherwise resp_valid=0.
REQ-031 A write at address A in cycle N followed by a read of A in cycle N+1 SHALL return the new data; no bypass is required.
REQ-032 Simultaneous write and read to the same address SHALL follow REQ-026/REQ-028 ordering; no merging.
REQ-033 When neither request is valid in RUN, sram_en SHALL be 0.
REQ-034 The init counter SHALL be ADDR_W+1 bits wide so the terminal count at DEPTH does not alias to 0.

Reset
REQ-035 Reset SHALL force: state=INIT, init counter=0, starvation counter=0, init_done=0, resp_valid=0.
REQ-036 Reset asserted mid-operation SHALL drop any in-flight response (resp_valid=0 next cycle) and restart the INIT sweep from address 0.
REQ-037 During reset, sram_en SHALL be 0.

Verification
REQ-038 Release reset: sram_en=1 and sram_wmode=1 on addresses 0..255 with wdata=0 over 256 cycles; init_done=1 afterwards; both readies are 0 throughout.
REQ-039 After init, write 0x1ABC to 0x05, then read 0x05 the next cycle: resp_valid one cycle after the read handshake with resp_data=0x1ABC.
REQ-040 Read 0x80 without writing it first: resp_data=0.
REQ-041 Hold w_valid and r_valid high continuously: the grant pattern is 4 writes, 1 read, repeating; each read gets resp_valid one cycle later.
REQ-042 Assert reset in the cycle after a read handshake: resp_valid=0 and the INIT sweep restarts at address 0.
REQ-043 Issue write and read to the same address 0x10 in the same cycle with the starvation counter at 0: the write wins; the read issued the next cycle returns the written data.
